// File: rtl/layer_memory_controller_if.sv
// Engine-side bus bundle for layer_memory_controller: per-layer request slices
// driven by the conv engines and the shared read-data returns.
interface layer_memory_controller_if #(
    parameter int NUM_LAYERS   = 2,
    parameter int H_ADDR_W     = 18,
    parameter int H_DATA_WIDTH = 19,
    parameter int WH_ADDR_W    = 14,
    parameter int WH_WIDTH     = 201,
    parameter int FEAT_ADDR_W  = 16,
    parameter int FEAT_WIDTH   = 32
);
    logic [NUM_LAYERS-1:0]             layer_done;
    logic [NUM_LAYERS-1:0]             h_rd_en;
    logic [NUM_LAYERS*H_ADDR_W-1:0]    h_rd_addr;
    logic [H_DATA_WIDTH-1:0]           h_dout;
    logic                              h_dout_vld;
    logic [NUM_LAYERS-1:0]             wh_wr_en;
    logic [NUM_LAYERS*WH_ADDR_W-1:0]   wh_wr_addr;
    logic [NUM_LAYERS*WH_WIDTH-1:0]    wh_din;
    logic [NUM_LAYERS-1:0]             wh_rd_en;
    logic [NUM_LAYERS*WH_ADDR_W-1:0]   wh_rd_addr;
    logic [WH_WIDTH-1:0]               wh_dout;
    logic                              wh_dout_vld;
    logic [NUM_LAYERS-1:0]             ft_wr_en;
    logic [NUM_LAYERS*FEAT_ADDR_W-1:0] ft_wr_addr;
    logic [NUM_LAYERS*FEAT_WIDTH-1:0]  ft_din;
    logic [NUM_LAYERS-1:0]             ft_rd_en;
    logic [NUM_LAYERS*FEAT_ADDR_W-1:0] ft_rd_addr;
    logic [FEAT_WIDTH-1:0]             ft_dout;
    logic                              ft_dout_vld;

    modport master (
        output layer_done, h_rd_en, h_rd_addr,
        output wh_wr_en, wh_wr_addr, wh_din, wh_rd_en, wh_rd_addr,
        output ft_wr_en, ft_wr_addr, ft_din, ft_rd_en, ft_rd_addr,
        input  h_dout, h_dout_vld, wh_dout, wh_dout_vld, ft_dout, ft_dout_vld
    );

    modport slave (
        input  layer_done, h_rd_en, h_rd_addr,
        input  wh_wr_en, wh_wr_addr, wh_din, wh_rd_en, wh_rd_addr,
        input  ft_wr_en, ft_wr_addr, ft_din, ft_rd_en, ft_rd_addr,
        output h_dout, h_dout_vld, wh_dout, wh_dout_vld, ft_dout, ft_dout_vld
    );
endinterface

// File: rtl/layer_memory_controller.sv
// N-layer GAT memory controller: layer sequencer, per-layer port mux, H/WH memories
// and ping-pong feature banks. Optional run-cycle counter: LAYER_MEM_CTRL_PERF_CNT_EN.
module layer_memory_controller #(
    parameter int NUM_LAYERS   = 2,
    parameter int H_DATA_WIDTH = 19,
    parameter int H_DEPTH      = 242101,
    parameter int WH_WIDTH     = 201,
    parameter int WH_DEPTH     = 13264,
    parameter int FEAT_WIDTH   = 32,
    parameter int FEAT_DEPTH   = 43328,
    parameter int CNT_W        = 32,
    localparam int LAYER_W     = $clog2(NUM_LAYERS),
    localparam int H_ADDR_W    = $clog2(H_DEPTH),
    localparam int WH_ADDR_W   = $clog2(WH_DEPTH),
    localparam int FEAT_ADDR_W = $clog2(FEAT_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ps_h_wr_en,
    input  logic [H_ADDR_W-1:0]     ps_h_addr,
    input  logic [H_DATA_WIDTH-1:0] ps_h_din,
    input  logic                    ps_load_done,
    output logic                    ps_wr_err,
    input  logic                    start,
    output logic [LAYER_W-1:0]      cur_layer,
    output logic                    busy,
    output logic                    all_done,
    input  logic [FEAT_ADDR_W-1:0]  ps_ft_addr,
    output logic [FEAT_WIDTH-1:0]   ps_ft_dout,
    output logic [CNT_W-1:0]        run_cycles,
    layer_memory_controller_if.slave eng
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_RUN   = 3'd2,
        ST_SWAP  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
    localparam logic [LAYER_W-1:0] LAYER_ONE  = LAYER_W'(1'b1);

    state_t                  state_q, state_d;
    logic [LAYER_W-1:0]      cur_layer_q, cur_layer_d;
    logic                    bank_sel_q, bank_sel_d;
    logic                    loaded_q, loaded_d;
    logic                    busy_q, busy_d;
    logic                    all_done_q, all_done_d;
    logic                    ps_wr_err_q, ps_wr_err_d;
    logic                    running_s;
    logic                    in_swap_s;
    logic                    ps_h_wr_ok_s;

    logic                    h_rd_sel_s, wh_wr_sel_s, wh_rd_sel_s, ft_wr_sel_s, ft_rd_sel_s;
    logic [H_ADDR_W-1:0]     h_rd_addr_s;
    logic [WH_ADDR_W-1:0]    wh_wr_addr_s, wh_rd_addr_s;
    logic [WH_WIDTH-1:0]     wh_din_s;
    logic [FEAT_ADDR_W-1:0]  ft_wr_addr_s, ft_rd_addr_s;
    logic [FEAT_WIDTH-1:0]   ft_din_s;
    int                      layer_idx_s;

    logic [H_DATA_WIDTH-1:0] h_dout_q, h_dout_d;
    logic                    h_dout_vld_q;
    logic [WH_WIDTH-1:0]     wh_dout_q, wh_dout_d;
    logic                    wh_dout_vld_q;
    logic [FEAT_WIDTH-1:0]   ft_dout_q, ft_dout_d;
    logic                    ft_dout_vld_q;
    logic [FEAT_WIDTH-1:0]   ps_ft_dout_q, ps_ft_dout_d;

    logic [H_DATA_WIDTH-1:0] h_mem    [H_DEPTH];
    logic [WH_WIDTH-1:0]     wh_mem   [WH_DEPTH];
    logic [FEAT_WIDTH-1:0]   ft_bank0 [FEAT_DEPTH];
    logic [FEAT_WIDTH-1:0]   ft_bank1 [FEAT_DEPTH];

    // Select the active layer's slice of every engine bus; SWAP masks all enables.
    always_comb begin
        running_s    = (state_q == ST_RUN) || (state_q == ST_SWAP);
        in_swap_s    = (state_q == ST_SWAP);
        ps_h_wr_ok_s = ps_h_wr_en && !running_s;
        layer_idx_s  = int'(cur_layer_q);
        h_rd_sel_s   = eng.h_rd_en[cur_layer_q]  && !in_swap_s;
        wh_wr_sel_s  = eng.wh_wr_en[cur_layer_q] && !in_swap_s;
        wh_rd_sel_s  = eng.wh_rd_en[cur_layer_q] && !in_swap_s;
        ft_wr_sel_s  = eng.ft_wr_en[cur_layer_q] && !in_swap_s;
        ft_rd_sel_s  = eng.ft_rd_en[cur_layer_q] && !in_swap_s;
        h_rd_addr_s  = eng.h_rd_addr[layer_idx_s*H_ADDR_W +: H_ADDR_W];
        wh_wr_addr_s = eng.wh_wr_addr[layer_idx_s*WH_ADDR_W +: WH_ADDR_W];
        wh_rd_addr_s = eng.wh_rd_addr[layer_idx_s*WH_ADDR_W +: WH_ADDR_W];
        wh_din_s     = eng.wh_din[layer_idx_s*WH_WIDTH +: WH_WIDTH];
        ft_wr_addr_s = eng.ft_wr_addr[layer_idx_s*FEAT_ADDR_W +: FEAT_ADDR_W];
        ft_rd_addr_s = eng.ft_rd_addr[layer_idx_s*FEAT_ADDR_W +: FEAT_ADDR_W];
        ft_din_s     = eng.ft_din[layer_idx_s*FEAT_WIDTH +: FEAT_WIDTH];
    end

    // Layer sequencer next-state and registered status outputs.
    always_comb begin
        state_d     = state_q;
        cur_layer_d = cur_layer_q;
        bank_sel_d  = bank_sel_q;
        loaded_d    = loaded_q;
        case (state_q)
            ST_IDLE: begin
                if (ps_load_done) begin
                    loaded_d = 1'b1;
                    state_d  = ST_READY;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_READY: begin
                if (start && loaded_q) begin
                    state_d     = ST_RUN;
                    cur_layer_d = {LAYER_W{1'b0}};
                end else begin
                    state_d     = ST_READY;
                end
            end
            ST_RUN: begin
                if (eng.layer_done[cur_layer_q]) begin
                    if (cur_layer_q == LAST_LAYER) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SWAP;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_SWAP: begin
                bank_sel_d  = ~bank_sel_q;
                cur_layer_d = cur_layer_q + LAYER_ONE;
                state_d     = ST_RUN;
            end
            ST_DONE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    cur_layer_d = {LAYER_W{1'b0}};
                end else if (ps_load_done) begin
                    state_d     = ST_READY;
                    loaded_d    = 1'b1;
                end else begin
                    state_d     = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d      = (state_d == ST_RUN) || (state_d == ST_SWAP);
        all_done_d  = (state_d == ST_DONE);
        ps_wr_err_d = ps_h_wr_en && running_s;
    end

    // Read-data return paths; each dout holds when its enable is low.
    always_comb begin
        h_dout_d  = h_dout_q;
        wh_dout_d = wh_dout_q;
        ft_dout_d = ft_dout_q;
        if (h_rd_sel_s) begin
            h_dout_d = h_mem[h_rd_addr_s];
        end else begin
            h_dout_d = h_dout_q;
        end
        if (wh_rd_sel_s) begin
            wh_dout_d = wh_mem[wh_rd_addr_s];
        end else begin
            wh_dout_d = wh_dout_q;
        end
        // Engines read the bank the previous layer filled, i.e. the one not being written.
        if (ft_rd_sel_s) begin
            ft_dout_d = bank_sel_q ? ft_bank0[ft_rd_addr_s] : ft_bank1[ft_rd_addr_s];
        end else begin
            ft_dout_d = ft_dout_q;
        end
        ps_ft_dout_d = bank_sel_q ? ft_bank1[ps_ft_addr] : ft_bank0[ps_ft_addr];
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cur_layer_q   <= {LAYER_W{1'b0}};
            bank_sel_q    <= 1'b0;
            loaded_q      <= 1'b0;
            busy_q        <= 1'b0;
            all_done_q    <= 1'b0;
            ps_wr_err_q   <= 1'b0;
            h_dout_q      <= {H_DATA_WIDTH{1'b0}};
            h_dout_vld_q  <= 1'b0;
            wh_dout_q     <= {WH_WIDTH{1'b0}};
            wh_dout_vld_q <= 1'b0;
            ft_dout_q     <= {FEAT_WIDTH{1'b0}};
            ft_dout_vld_q <= 1'b0;
            ps_ft_dout_q  <= {FEAT_WIDTH{1'b0}};
        end else begin
            state_q       <= state_d;
            cur_layer_q   <= cur_layer_d;
            bank_sel_q    <= bank_sel_d;
            loaded_q      <= loaded_d;
            busy_q        <= busy_d;
            all_done_q    <= all_done_d;
            ps_wr_err_q   <= ps_wr_err_d;
            h_dout_q      <= h_dout_d;
            h_dout_vld_q  <= h_rd_sel_s;
            wh_dout_q     <= wh_dout_d;
            wh_dout_vld_q <= wh_rd_sel_s;
            ft_dout_q     <= ft_dout_d;
            ft_dout_vld_q <= ft_rd_sel_s;
            ps_ft_dout_q  <= ps_ft_dout_d;
        end
    end

    // Memory arrays carry no reset so their contents survive rst_n.
    always_ff @(posedge clk) begin
        if (ps_h_wr_ok_s) begin
            h_mem[ps_h_addr] <= ps_h_din;
        end
        if (wh_wr_sel_s) begin
            wh_mem[wh_wr_addr_s] <= wh_din_s;
        end
        if (ft_wr_sel_s) begin
            if (bank_sel_q) begin
                ft_bank1[ft_wr_addr_s] <= ft_din_s;
            end else begin
                ft_bank0[ft_wr_addr_s] <= ft_din_s;
            end
        end
    end

`ifdef LAYER_MEM_CTRL_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
    logic [CNT_W-1:0] run_cycles_q, run_cycles_d;

    // Saturating count of RUN/SWAP cycles, cleared by an accepted start.
    always_comb begin
        run_cycles_d = run_cycles_q;
        if (start && ((state_q == ST_READY && loaded_q) || state_q == ST_DONE)) begin
            run_cycles_d = {CNT_W{1'b0}};
        end else if (running_s && (run_cycles_q != {CNT_W{1'b1}})) begin
            run_cycles_d = run_cycles_q + CNT_ONE;
        end else begin
            run_cycles_d = run_cycles_q;
        end
    end

    // Performance counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cycles_q <= {CNT_W{1'b0}};
        end else begin
            run_cycles_q <= run_cycles_d;
        end
    end

    assign run_cycles = run_cycles_q;
`else
    assign run_cycles = {CNT_W{1'b0}};
`endif

    assign cur_layer       = cur_layer_q;
    assign busy            = busy_q;
    assign all_done        = all_done_q;
    assign ps_wr_err       = ps_wr_err_q;
    assign ps_ft_dout      = ps_ft_dout_q;
    assign eng.h_dout      = h_dout_q;
    assign eng.h_dout_vld  = h_dout_vld_q;
    assign eng.wh_dout     = wh_dout_q;
    assign eng.wh_dout_vld = wh_dout_vld_q;
    assign eng.ft_dout     = ft_dout_q;
    assign eng.ft_dout_vld = ft_dout_vld_q;

endmodule

// File: tb/tb_layer_memory_controller.sv
// Directed-plus-random bench for layer_memory_controller (3 layers, small memories)
// checked against a dataflow model: H/WH arrays and per-layer feature outputs.
module tb_layer_memory_controller;
    localparam int NL  = 3;
    localparam int HDW = 19;
    localparam int HD  = 64;
    localparam int HAW = $clog2(HD);
    localparam int WHW = 201;
    localparam int WHD = 32;
    localparam int WAW = $clog2(WHD);
    localparam int FW  = 32;
    localparam int FD  = 64;
    localparam int FAW = $clog2(FD);
    localparam int CW  = 32;
`ifdef LAYER_MEM_CTRL_PERF_CNT_EN
    localparam int PERF_EXP = 12;
`else
    localparam int PERF_EXP = 0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           ps_h_wr_en = 1'b0;
    logic [HAW-1:0] ps_h_addr = '0;
    logic [HDW-1:0] ps_h_din = '0;
    logic           ps_load_done = 1'b0;
    logic           ps_wr_err;
    logic           start = 1'b0;
    logic [1:0]     cur_layer;
    logic           busy;
    logic           all_done;
    logic [FAW-1:0] ps_ft_addr = '0;
    logic [FW-1:0]  ps_ft_dout;
    logic [CW-1:0]  run_cycles;

    layer_memory_controller_if #(
        .NUM_LAYERS(NL), .H_ADDR_W(HAW), .H_DATA_WIDTH(HDW), .WH_ADDR_W(WAW),
        .WH_WIDTH(WHW), .FEAT_ADDR_W(FAW), .FEAT_WIDTH(FW)
    ) eng ();

    layer_memory_controller #(
        .NUM_LAYERS(NL), .H_DATA_WIDTH(HDW), .H_DEPTH(HD), .WH_WIDTH(WHW),
        .WH_DEPTH(WHD), .FEAT_WIDTH(FW), .FEAT_DEPTH(FD), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ps_h_wr_en(ps_h_wr_en), .ps_h_addr(ps_h_addr),
        .ps_h_din(ps_h_din), .ps_load_done(ps_load_done), .ps_wr_err(ps_wr_err),
        .start(start), .cur_layer(cur_layer), .busy(busy), .all_done(all_done),
        .ps_ft_addr(ps_ft_addr), .ps_ft_dout(ps_ft_dout), .run_cycles(run_cycles),
        .eng(eng)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    int cur_m  = 0;
    logic [HDW-1:0] h_m      [HD];
    logic [WHW-1:0] wh_m     [WHD];
    logic [FW-1:0]  feat_out [NL][FD];
    int             fa       [NL][5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Random traffic on every slice; the active layer's enables are left low.
    task automatic bg();
        eng.layer_done = NL'($urandom());
        eng.h_rd_en    = NL'($urandom());
        eng.wh_wr_en   = NL'($urandom());
        eng.wh_rd_en   = NL'($urandom());
        eng.ft_wr_en   = NL'($urandom());
        eng.ft_rd_en   = NL'($urandom());
        for (int l = 0; l < NL; l++) begin
            eng.h_rd_addr[l*HAW +: HAW]  = HAW'($urandom());
            eng.wh_wr_addr[l*WAW +: WAW] = WAW'($urandom());
            eng.wh_rd_addr[l*WAW +: WAW] = WAW'($urandom());
            eng.wh_din[l*WHW +: WHW]     = WHW'(rnd256());
            eng.ft_wr_addr[l*FAW +: FAW] = FAW'($urandom());
            eng.ft_rd_addr[l*FAW +: FAW] = FAW'($urandom());
            eng.ft_din[l*FW +: FW]       = FW'($urandom());
        end
        eng.layer_done[cur_m] = 1'b0;
        eng.h_rd_en[cur_m]    = 1'b0;
        eng.wh_wr_en[cur_m]   = 1'b0;
        eng.wh_rd_en[cur_m]   = 1'b0;
        eng.ft_wr_en[cur_m]   = 1'b0;
        eng.ft_rd_en[cur_m]   = 1'b0;
    endtask

    task automatic idle_cycle();
        bg();
        tick();
    endtask

    task automatic ps_write(input int a, input logic [HDW-1:0] d, input bit accept);
        bg();
        ps_h_wr_en = 1'b1;
        ps_h_addr  = HAW'(a);
        ps_h_din   = d;
        tick();
        ps_h_wr_en = 1'b0;
        if (accept) h_m[a] = d;
        chk("ps_wr_err", ps_wr_err, !accept);
    endtask

    task automatic pulse_load_done();
        bg();
        ps_load_done = 1'b1;
        tick();
        ps_load_done = 1'b0;
    endtask

    task automatic pulse_start();
        bg();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic h_rd(input int a);
        bg();
        eng.h_rd_en[cur_m] = 1'b1;
        eng.h_rd_addr[cur_m*HAW +: HAW] = HAW'(a);
        tick();
        chk("h_dout", eng.h_dout, h_m[a]);
        chk("h_vld", eng.h_dout_vld, 1'b1);
    endtask

    task automatic wh_op(input bit do_wr, input int wa, input logic [WHW-1:0] wd,
                         input bit do_rd, input int ra);
        logic [WHW-1:0] exp_rd;
        exp_rd = wh_m[ra];
        bg();
        eng.wh_wr_en[cur_m] = do_wr;
        eng.wh_wr_addr[cur_m*WAW +: WAW] = WAW'(wa);
        eng.wh_din[cur_m*WHW +: WHW] = wd;
        eng.wh_rd_en[cur_m] = do_rd;
        eng.wh_rd_addr[cur_m*WAW +: WAW] = WAW'(ra);
        tick();
        if (do_wr) wh_m[wa] = wd;
        if (do_rd) chk("wh_dout", eng.wh_dout, exp_rd);
        chk("wh_vld", eng.wh_dout_vld, do_rd);
    endtask

    task automatic ft_wr(input int a, input logic [FW-1:0] d);
        bg();
        eng.ft_wr_en[cur_m] = 1'b1;
        eng.ft_wr_addr[cur_m*FAW +: FAW] = FAW'(a);
        eng.ft_din[cur_m*FW +: FW] = d;
        tick();
        feat_out[cur_m][a] = d;
    endtask

    task automatic ft_rd(input int a);
        bg();
        eng.ft_rd_en[cur_m] = 1'b1;
        eng.ft_rd_addr[cur_m*FAW +: FAW] = FAW'(a);
        tick();
        chk("ft_dout", eng.ft_dout, feat_out[cur_m-1][a]);
        chk("ft_vld", eng.ft_dout_vld, 1'b1);
    endtask

    task automatic layer_writes(input logic [FW-1:0] d7);
        fa[cur_m][0] = 7;
        ft_wr(7, d7);
        for (int i = 1; i < 5; i++) begin
            fa[cur_m][i] = $urandom_range(8, FD-1);
            ft_wr(fa[cur_m][i], FW'($urandom()));
        end
    endtask

    task automatic wrong_done(input int l);
        bg();
        eng.layer_done[l] = 1'b1;
        tick();
        idle_cycle();
        chk("wrong_done_layer", cur_layer, cur_m);
        chk("wrong_done_busy", busy, 1'b1);
    endtask

    // Completes the active layer; SWAP-cycle requests must all be masked.
    task automatic finish_layer();
        bg();
        eng.layer_done[cur_m] = 1'b1;
        tick();
        if (cur_m < NL-1) begin
            chk("swap_busy", busy, 1'b1);
            chk("swap_layer", cur_layer, cur_m);
            bg();
            eng.h_rd_en[cur_m]  = 1'b1;
            eng.h_rd_addr[cur_m*HAW +: HAW] = HAW'(5);
            eng.ft_wr_en[cur_m] = 1'b1;
            eng.ft_wr_addr[cur_m*FAW +: FAW] = FAW'(7);
            eng.ft_din[cur_m*FW +: FW] = 32'hBAD0_BAD0;
            eng.wh_wr_en[cur_m] = 1'b1;
            eng.wh_wr_addr[cur_m*WAW +: WAW] = WAW'(3);
            eng.wh_din[cur_m*WHW +: WHW] = {WHW{1'b1}};
            tick();
            cur_m++;
            chk("next_layer", cur_layer, cur_m);
            chk("next_busy", busy, 1'b1);
            chk("swap_mask_vld", eng.h_dout_vld, 1'b0);
        end else begin
            chk("done_all_done", all_done, 1'b1);
            chk("done_busy", busy, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wa_prev;
        logic [WHW-1:0] wd;
        eng.layer_done = '0; eng.h_rd_en = '0; eng.wh_wr_en = '0; eng.wh_rd_en = '0;
        eng.ft_wr_en = '0; eng.ft_rd_en = '0; eng.h_rd_addr = '0; eng.wh_wr_addr = '0;
        eng.wh_rd_addr = '0; eng.wh_din = '0; eng.ft_wr_addr = '0; eng.ft_rd_addr = '0;
        eng.ft_din = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_all_done", all_done, 1'b0);
        chk("rst_wr_err", ps_wr_err, 1'b0);
        chk("rst_layer", cur_layer, 2'd0);
        chk("rst_h_vld", eng.h_dout_vld, 1'b0);
        chk("rst_wh_vld", eng.wh_dout_vld, 1'b0);
        chk("rst_ft_vld", eng.ft_dout_vld, 1'b0);
        chk("rst_h_dout", eng.h_dout, '0);
        chk("rst_wh_dout", eng.wh_dout, '0);
        chk("rst_ft_dout", eng.ft_dout, '0);
        chk("rst_ps_ft", ps_ft_dout, '0);
        chk("rst_run_cycles", run_cycles, '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        pulse_start();
        chk("idle_start_ignored", busy, 1'b0);
        ps_write(5, 19'h1A, 1'b1);
        for (int i = 10; i < 18; i++) ps_write(i, HDW'($urandom()), 1'b1);
        pulse_load_done();
        chk("ready_busy", busy, 1'b0);
        pulse_start();
        chk("run_busy", busy, 1'b1);
        chk("run_layer0", cur_layer, 2'd0);

        h_rd(5);
        idle_cycle();
        chk("h_vld_low", eng.h_dout_vld, 1'b0);
        chk("h_dout_hold", eng.h_dout, 19'h1A);
        for (int i = 0; i < 4; i++) h_rd($urandom_range(10, 17));
        ps_write(5, 19'h2B5, 1'b0);
        idle_cycle();
        chk("wr_err_pulse_end", ps_wr_err, 1'b0);
        h_rd(5);

        wh_op(1'b1, 3, WHW'(8'h11), 1'b0, 3);
        wh_op(1'b1, 3, WHW'(8'h22), 1'b1, 3);
        wh_op(1'b0, 0, '0, 1'b1, 3);
        wa_prev = 8;
        for (int i = 0; i < 6; i++) begin
            int wa;
            wa = $urandom_range(8, WHD-1);
            wd = WHW'(rnd256());
            wh_op(1'b1, wa, wd, i > 0, wa_prev);
            wa_prev = wa;
        end

        layer_writes(32'h0000_DEAD);
        wrong_done(2);
        finish_layer();

        wh_op(1'b0, 0, '0, 1'b1, 3);
        for (int i = 0; i < 5; i++) ft_rd(fa[0][i]);
        layer_writes(32'h0000_BEEF);
        wrong_done(2);
        finish_layer();

        for (int i = 0; i < 5; i++) ft_rd(fa[1][i]);
        layer_writes(32'hC0FF_EE01);
        finish_layer();

        for (int i = 0; i < 5; i++) begin
            bg();
            ps_ft_addr = FAW'(fa[2][i]);
            tick();
            tick();
            chk("ps_ft_dout", ps_ft_dout, feat_out[2][fa[2][i]]);
        end
        ps_write(20, HDW'($urandom()), 1'b1);

        pulse_start();
        chk("restart_all_done", all_done, 1'b0);
        chk("restart_busy", busy, 1'b1);
        cur_m = 0;
        chk("restart_layer", cur_layer, 2'd0);
        for (int l = 0; l < NL; l++) begin
            repeat ((l == NL-1) ? 3 : 2) idle_cycle();
            finish_layer();
        end
        chk("run_cycles", run_cycles, PERF_EXP);
        repeat (3) idle_cycle();
        chk("run_cycles_hold", run_cycles, PERF_EXP);

        pulse_load_done();
        chk("reload_all_done", all_done, 1'b0);
        chk("reload_busy", busy, 1'b0);
        pulse_start();
        cur_m = 0;
        finish_layer();
        chk("pre_reset_layer", cur_layer, 2'd1);
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_busy", busy, 1'b0);
        chk("midrun_rst_layer", cur_layer, 2'd0);
        chk("midrun_rst_h_vld", eng.h_dout_vld, 1'b0);
        cur_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        pulse_load_done();
        pulse_start();
        h_rd(5);
        h_rd(20);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
